// File: rtl/skip_decoder.sv
// skip_decoder: recovers the per-revolution skip pattern of a gated clock.
// A LEN-phase ring is tracked by a phase counter that advances on every
// enabled cycle. One revolution is captured, a second revolution must
// reproduce it bit for bit, and only then is the mask published and LOCK
// raised. While locked, any deviating bit or a phase slip (B0 absent at
// phase 0) reports ERR and drops back to HUNT.
//
// Handshake: there is no backpressure. VALID is a one-cycle strobe that is
// high exactly in the cycle MASK_OUT takes a new value. The consumer must
// sample MASK_OUT while VALID is high or at any later time; MASK_OUT holds
// until the next VALID.
//
// STATE exposes the FSM state: 0 HUNT, 1 CAPTURE, 2 VERIFY, 3 LOCKED.
module skip_decoder #(
   parameter int LEN = 16,
   parameter int CW  = 5
) (
   input  logic           iCLK,
   input  logic           nRST,
   input  logic           E,
   input  logic           B0,
   input  logic           CLKEN,
   output logic [LEN-1:0] MASK_OUT,
   output logic           VALID,
   output logic           LOCK,
   output logic           ERR,
   output logic [CW-1:0]  SKIPCNT,
   output logic [1:0]     STATE
);

   localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;

   localparam logic [1:0] S_HUNT    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_VERIFY  = 2'd2;
   localparam logic [1:0] S_LOCKED  = 2'd3;

   logic [1:0]     state;
   logic [PW-1:0]  ph;
   logic [LEN-1:0] cap;
   logic [LEN-1:0] ref_q;
   logic           mm;

   logic           bit_now;
   logic [LEN-1:0] cap_nxt;
   logic [LEN-1:0] cap_first;
   logic           rev_end;
   logic [PW-1:0]  ph_nxt;
   logic           mis;
   logic           slip;
   logic           mm_all;
   logic [CW-1:0]  pop_nxt;

   // Number of set bits in a captured revolution.
   function automatic logic [CW-1:0] popcount(input logic [LEN-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < LEN; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // Per-sample decode: captured bit, next phase, mismatch and slip flags.
   always_comb begin
      bit_now      = ~CLKEN;
      cap_nxt      = cap;
      cap_nxt[ph]  = bit_now;
      cap_first    = '0;
      cap_first[0] = bit_now;
      rev_end      = (ph == PW'(LEN - 1));
      ph_nxt       = rev_end ? '0 : ph + PW'(1);
      mis          = (bit_now != ref_q[ph]);
      slip         = (ph == '0) && !B0;
      mm_all       = mm | mis;
      pop_nxt      = popcount(cap_nxt);
   end

   // FSM, capture/reference registers and all registered outputs.
   always_ff @(posedge iCLK or negedge nRST) begin
      if (!nRST) begin
         state    <= S_HUNT;
         ph       <= '0;
         cap      <= '0;
         ref_q    <= '0;
         mm       <= 1'b0;
         MASK_OUT <= '0;
         VALID    <= 1'b0;
         LOCK     <= 1'b0;
         ERR      <= 1'b0;
         SKIPCNT  <= '0;
      end else begin
         VALID <= 1'b0;
         ERR   <= 1'b0;
         if (E) begin
            case (state)
               S_HUNT: begin
                  if (B0) begin
                     cap   <= cap_first;
                     ph    <= PW'(1);
                     state <= S_CAPTURE;
                  end else begin
                     ph <= '0;
                  end
               end
               S_CAPTURE: begin
                  cap <= cap_nxt;
                  ph  <= ph_nxt;
                  if (rev_end) begin
                     ref_q   <= cap_nxt;
                     SKIPCNT <= pop_nxt;
                     mm      <= 1'b0;
                     state   <= S_VERIFY;
                  end
               end
               S_VERIFY: begin
                  if (slip) begin
                     // A slip and a mismatch together still give one ERR.
                     ERR   <= 1'b1;
                     state <= S_HUNT;
                     ph    <= '0;
                     cap   <= '0;
                     mm    <= 1'b0;
                  end else begin
                     cap <= cap_nxt;
                     ph  <= ph_nxt;
                     mm  <= mm_all;
                     if (rev_end) begin
                        SKIPCNT <= pop_nxt;
                        mm      <= 1'b0;
                        if (!mm_all) begin
                           state    <= S_LOCKED;
                           MASK_OUT <= ref_q;
                           VALID    <= 1'b1;
                           LOCK     <= 1'b1;
                        end else begin
                           // Retry with the newest revolution as reference.
                           ref_q <= cap_nxt;
                           ERR   <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  if (slip || mis) begin
                     ERR   <= 1'b1;
                     LOCK  <= 1'b0;
                     state <= S_HUNT;
                     ph    <= '0;
                     cap   <= '0;
                     mm    <= 1'b0;
                  end else begin
                     cap <= cap_nxt;
                     ph  <= ph_nxt;
                     if (rev_end) begin
                        SKIPCNT <= pop_nxt;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign STATE = state;

endmodule

// File: tb/tb_skip_decoder.sv
// Directed bench for skip_decoder (LEN=16, CW=5).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. A revolution helper drives 16 enabled cycles (optionally
// with a block of disabled cycles inserted) and records VALID/ERR pulses.
module tb_skip_decoder;

   logic        iCLK = 1'b0;
   logic        nRST = 1'b0;
   logic        E = 1'b0;
   logic        B0 = 1'b0;
   logic        CLKEN = 1'b1;
   logic [15:0] MASK_OUT;
   logic        VALID;
   logic        LOCK;
   logic        ERR;
   logic [4:0]  SKIPCNT;
   logic [1:0]  STATE;

   int checks = 0;
   int errors = 0;

   // pulse bookkeeping for the current revolution
   int r_cyc;
   int r_nv;
   int r_ne;
   int r_vidx;
   int r_eidx;

   int t031;
   int t033;
   int len1;

   skip_decoder #(.LEN(16), .CW(5)) dut (
      .iCLK(iCLK), .nRST(nRST), .E(E), .B0(B0), .CLKEN(CLKEN),
      .MASK_OUT(MASK_OUT), .VALID(VALID), .LOCK(LOCK), .ERR(ERR),
      .SKIPCNT(SKIPCNT), .STATE(STATE)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one clock: drive on negedge, sample after posedge, log pulses
   task automatic step(input logic e, input logic b0, input logic ck);
      @(negedge iCLK);
      E = e; B0 = b0; CLKEN = ck;
      @(posedge iCLK);
      #1;
      if (VALID) begin r_nv++; r_vidx = r_cyc; end
      if (ERR)   begin r_ne++; r_eidx = r_cyc; end
      r_cyc++;
   endtask

   // 16 enabled cycles of pattern pat (1 = skipped), B0 at cycle b0pos,
   // with gap_len disabled random cycles inserted before the 9th one
   task automatic run_rev(input logic [15:0] pat, input int b0pos, input int gap_len);
      logic [3:0] p;
      r_cyc = 0; r_nv = 0; r_ne = 0; r_vidx = -1; r_eidx = -1;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            for (int g = 0; g < gap_len; g++) begin
               step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
         end
         p = 4'(i - b0pos);
         step(1'b1, (i == b0pos), ~pat[p]);
      end
   endtask

   task automatic do_reset();
      @(negedge iCLK);
      nRST = 1'b0; E = 1'b0; B0 = 1'b0; CLKEN = 1'b1;
      @(negedge iCLK);
      @(negedge iCLK);
      nRST = 1'b1;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_mask", 32'(MASK_OUT), 32'h0);
      check("rst_valid", 32'(VALID), 32'h0);
      check("rst_lock", 32'(LOCK), 32'h0);
      check("rst_err", 32'(ERR), 32'h0);
      check("rst_skipcnt", 32'(SKIPCNT), 32'h0);
      check("rst_state", 32'(STATE), 32'h0);
      do_reset();

      // basic lock on 0x0005
      run_rev(16'h0005, 0, 0);
      check("r1_valid_cnt", 32'(r_nv), 0);
      check("r1_err_cnt", 32'(r_ne), 0);
      check("r1_lock", 32'(LOCK), 0);
      check("r1_state", 32'(STATE), 2);
      check("r1_skipcnt", 32'(SKIPCNT), 2);
      len1 = r_cyc;
      run_rev(16'h0005, 0, 0);
      check("r2_valid_cnt", 32'(r_nv), 1);
      check("r2_valid_idx", 32'(r_vidx), 15);
      check("r2_err_cnt", 32'(r_ne), 0);
      check("r2_lock", 32'(LOCK), 1);
      check("r2_state", 32'(STATE), 3);
      check("r2_mask", 32'(MASK_OUT), 32'h0005);
      check("r2_skipcnt", 32'(SKIPCNT), 2);
      t031 = len1 + r_vidx;
      check("r2_latency", 32'(t031), 31);

      // locked, CLKEN=1 at phase 2 -> mismatch
      run_rev(16'h0001, 0, 0);
      check("brk_err_cnt", 32'(r_ne), 1);
      check("brk_err_idx", 32'(r_eidx), 2);
      check("brk_lock", 32'(LOCK), 0);
      check("brk_state", 32'(STATE), 0);
      check("brk_mask", 32'(MASK_OUT), 32'h0005);

      // relock, then B0 one cycle late -> slip at the PH=0 sample
      run_rev(16'h0005, 0, 0);
      run_rev(16'h0005, 0, 0);
      check("relock_lock", 32'(LOCK), 1);
      run_rev(16'h0005, 1, 0);
      check("slip_err_cnt", 32'(r_ne), 1);
      check("slip_err_idx", 32'(r_eidx), 0);
      check("slip_lock", 32'(LOCK), 0);
      check("slip_state", 32'(STATE), 1);
      step(1'b1, 1'b0, 1'b1);
      check("slip_cap_done", 32'(STATE), 2);
      run_rev(16'h0005, 0, 0);
      check("slip_relock_valid", 32'(r_nv), 1);
      check("slip_relock_idx", 32'(r_vidx), 15);
      check("slip_relock_lock", 32'(LOCK), 1);
      check("slip_relock_mask", 32'(MASK_OUT), 32'h0005);

      // reset pulsed mid-VERIFY: leave lock, recapture, stop partway
      run_rev(16'h0001, 0, 0);
      run_rev(16'h0005, 0, 0);
      for (int i = 0; i < 6; i++) step(1'b1, (i == 0), ~((i == 0) || (i == 2)));
      check("pre_rst_state", 32'(STATE), 2);
      @(negedge iCLK);
      nRST = 1'b0;
      #1;
      check("mid_rst_mask", 32'(MASK_OUT), 32'h0);
      check("mid_rst_skipcnt", 32'(SKIPCNT), 32'h0);
      check("mid_rst_state", 32'(STATE), 32'h0);
      check("mid_rst_lock", 32'(LOCK), 32'h0);
      check("mid_rst_valid", 32'(VALID), 32'h0);
      check("mid_rst_err", 32'(ERR), 32'h0);
      @(negedge iCLK);
      nRST = 1'b1;

      // 0x0005 then 0x8001 repeated
      run_rev(16'h0005, 0, 0);
      run_rev(16'h8001, 0, 0);
      check("pat_r2_err_cnt", 32'(r_ne), 1);
      check("pat_r2_err_idx", 32'(r_eidx), 15);
      check("pat_r2_lock", 32'(LOCK), 0);
      check("pat_r2_state", 32'(STATE), 2);
      run_rev(16'h8001, 0, 0);
      check("pat_r3_valid_idx", 32'(r_vidx), 15);
      check("pat_r3_err_cnt", 32'(r_ne), 0);
      check("pat_r3_lock", 32'(LOCK), 1);
      check("pat_r3_mask", 32'(MASK_OUT), 32'h8001);
      check("pat_r3_skipcnt", 32'(SKIPCNT), 2);

      // E=0 for 5 cycles in the first revolution
      do_reset();
      run_rev(16'h0005, 0, 5);
      len1 = r_cyc;
      check("gap_r1_len", 32'(len1), 21);
      check("gap_r1_state", 32'(STATE), 2);
      run_rev(16'h0005, 0, 0);
      check("gap_valid_cnt", 32'(r_nv), 1);
      check("gap_lock", 32'(LOCK), 1);
      check("gap_mask", 32'(MASK_OUT), 32'h0005);
      t033 = len1 + r_vidx;
      check("gap_latency", 32'(t033 - t031), 5);
      step(1'b1, 1'b1, 1'b0);
      check("gap_valid_drop", 32'(VALID), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
